// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field offsets, counter widths and a
// clog2 helper that never returns less than one bit.
package noc_pkg;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DROP_W = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned x_lo();
        return 0;
    endfunction

    function automatic int unsigned y_lo(input int unsigned xw);
        return xw;
    endfunction

    function automatic int unsigned seq_lo(input int unsigned xw, input int unsigned yw);
        return xw + yw;
    endfunction

endpackage

// File: rtl/noc_eject_unit_if.sv
// Flit handshake between switch local port, eject unit and PE interface.
interface noc_eject_unit_if #(
    parameter int unsigned total_width = 32
);
    logic [total_width-1:0] i_data;
    logic                   i_valid;
    logic                   o_ready;
    logic [total_width-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid
    );

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid
    );
endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with registered occupancy; head reads as zero when empty.
module noc_sync_fifo #(
    parameter int unsigned width = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [width-1:0]               wr_data,
    input  logic                           pop,
    output logic [width-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [width-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_eject_unit.sv
// NoC eject stage: filters flits by destination, buffers matches and tracks
// packet sequence. NOC_EJECT_STATS_EN builds the forward/drop counters.
module noc_eject_unit
    import noc_pkg::*;
#(
    parameter int unsigned X           = 0,
    parameter int unsigned Y           = 0,
    parameter int unsigned total_width = 32,
    parameter int unsigned x_size      = 4,
    parameter int unsigned y_size      = 4,
    parameter int unsigned pck_num     = 8,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_eject_unit_if.slave       bus,
    output logic [CNT_W-1:0]      o_rx_cnt,
    output logic [DROP_W-1:0]     o_drop_cnt,
    output logic                  o_seq_err
);
    localparam int unsigned XW    = clog2_min1(x_size);
    localparam int unsigned YW    = clog2_min1(y_size);
    localparam int unsigned SW    = clog2_min1(pck_num);
    localparam int unsigned XLO   = x_lo();
    localparam int unsigned YLO   = y_lo(XW);
    localparam int unsigned SEQLO = seq_lo(XW, YW);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic [XW-1:0]          dst_x;
    logic [YW-1:0]          dst_y;
    logic [SW-1:0]          seq;
    logic                   match;
    logic                   accept;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [SW-1:0]          exp_seq;

    assign dst_x = bus.i_data[XLO +: XW];
    assign dst_y = bus.i_data[YLO +: YW];
    assign seq   = bus.i_data[SEQLO +: SW];
    assign match = (dst_x == XW'(X)) && (dst_y == YW'(Y));

    // Ready comes only from registered occupancy, never from i_valid/i_ready.
    assign bus.o_ready = (fifo_count != CW'(DEPTH));
    assign accept      = bus.i_valid && !fifo_full;
    assign bus.o_valid = !fifo_empty;
    assign pop         = !fifo_empty && bus.i_ready;

    noc_sync_fifo #(
        .width (total_width),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept && match),
        .wr_data (bus.i_data),
        .pop     (pop),
        .rd_data (bus.o_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    function automatic logic [SW-1:0] seq_next(input logic [SW-1:0] s);
        return (s == SW'(pck_num - 1)) ? '0 : s + SW'(1);
    endfunction

    // On a gap, resynchronise to the received index so one loss flags once.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_seq   <= '0;
            o_seq_err <= 1'b0;
        end else if (accept && match) begin
            if (seq != exp_seq) begin
                o_seq_err <= 1'b1;
            end
            exp_seq <= seq_next(seq);
        end
    end

`ifdef NOC_EJECT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rx_cnt   <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (pop && (o_rx_cnt != '1)) begin
                o_rx_cnt <= o_rx_cnt + CNT_W'(1);
            end
            if (accept && !match && (o_drop_cnt != '1)) begin
                o_drop_cnt <= o_drop_cnt + DROP_W'(1);
            end
        end
    end
`else
    assign o_rx_cnt   = '0;
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_eject_unit.sv
// Scoreboard bench for noc_eject_unit: node (1,2) in a 4x4 mesh, 8 packets, depth 4.
module tb_noc_eject_unit;

`ifdef NOC_EJECT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_cnt;
    logic [15:0] drop_cnt;
    logic        seq_err;

    int checks = 0;
    int errors = 0;
    int exp_rx = 0;
    int exp_drop = 0;
    logic [15:0] exp_q[$];

    noc_eject_unit_if #(.total_width(16)) bus();

    noc_eject_unit #(
        .X(1), .Y(2), .total_width(16), .x_size(4), .y_size(4),
        .pck_num(8), .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_rx_cnt   (rx_cnt),
        .o_drop_cnt (drop_cnt),
        .o_seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [1:0] x, input logic [1:0] y,
                                       input logic [2:0] s, input logic [8:0] p);
        return {p, s, y, x};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one flit and hold it until accepted; matches go to the scoreboard.
    task automatic send(input logic [15:0] f, input bit is_match);
        bit ok = 1'b0;
        bus.i_data  = f;
        bus.i_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.o_ready;
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: flit %0h not accepted", f);
        end else if (is_match) begin
            exp_q.push_back(f);
        end else begin
            exp_drop++;
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(bus.o_valid), 32'd0);
    endtask

    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = '0;

    // Monitor: every handshake on the PE side must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && prev_hold) begin
            check("hold_valid", 32'(bus.o_valid), 32'd1);
            check("hold_data", 32'(bus.o_data), 32'(prev_data));
        end
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit: got %0h, expected no flit", bus.o_data);
            end else begin
                check("rx_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
                exp_rx++;
            end
        end
        prev_hold = !rst && bus.o_valid && !bus.i_ready;
        prev_data = bus.o_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_data  = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data", 32'(bus.o_data), 32'd0);
        check("rst_rx", rx_cnt, 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_seq_err", 32'(seq_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single match: visible the cycle after acceptance
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("pre_valid", 32'(bus.o_valid), 32'd0);
        @(posedge clk);
        #1;
        send(mk(2'd1, 2'd2, 3'd0, 9'h1a5), 1'b1);
        @(negedge clk);
        check("latency_valid", 32'(bus.o_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("single_rx", rx_cnt, STATS ? 32'd1 : 32'd0);
        check("single_seq_err", 32'(seq_err), 32'd0);
        check("single_empty", 32'(bus.o_valid), 32'd0);

        // Misroute: dropped and counted
        @(posedge clk);
        #1;
        send(mk(2'd3, 2'd0, 3'd1, 9'h0f0), 1'b0);
        @(negedge clk);
        check("misroute_valid", 32'(bus.o_valid), 32'd0);
        check("misroute_drop", 32'(drop_cnt), STATS ? 32'(exp_drop) : 32'd0);
        @(negedge clk);
        check("misroute_valid2", 32'(bus.o_valid), 32'd0);

        // Backpressure: four fill the FIFO, the fifth waits; then full+pop
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(mk(2'd1, 2'd2, 3'(i), 9'(9'h100 + i)), 1'b1);
        @(negedge clk);
        check("full_ready", 32'(bus.o_ready), 32'd0);
        check("full_valid", 32'(bus.o_valid), 32'd1);
        fork
            send(mk(2'd1, 2'd2, 3'd5, 9'h105), 1'b1);
            begin
                repeat (3) @(posedge clk);
                #2;
                check("full_still_blocked", 32'(bus.o_ready), 32'd0);
                bus.i_ready = 1'b1;
                @(negedge clk);
                check("full_pop_ready", 32'(bus.o_ready), 32'd0);
                @(negedge clk);
                check("after_pop_ready", 32'(bus.o_ready), 32'd1);
            end
        join
        wait_drain();
        check("bp_rx", rx_cnt, STATS ? 32'd6 : 32'd0);
        check("bp_seq_err", 32'(seq_err), 32'd0);

        // Sequence wrap 6,7,0 is clean; 2 instead of 1 sets a sticky error
        @(posedge clk);
        #1;
        send(mk(2'd1, 2'd2, 3'd6, 9'h006), 1'b1);
        send(mk(2'd1, 2'd2, 3'd7, 9'h007), 1'b1);
        send(mk(2'd1, 2'd2, 3'd0, 9'h008), 1'b1);
        @(negedge clk);
        check("wrap_seq_err", 32'(seq_err), 32'd0);
        @(posedge clk);
        #1;
        send(mk(2'd1, 2'd2, 3'd2, 9'h009), 1'b1);
        @(negedge clk);
        check("gap_seq_err", 32'(seq_err), 32'd1);
        @(posedge clk);
        #1;
        send(mk(2'd1, 2'd2, 3'd3, 9'h00a), 1'b1);
        wait_drain();
        check("sticky_seq_err", 32'(seq_err), 32'd1);
        check("wrap_rx", rx_cnt, STATS ? 32'(exp_rx) : 32'd0);

        // Mid-stream reset discards buffered flits
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        for (int i = 4; i <= 6; i++) send(mk(2'd1, 2'd2, 3'(i), 9'(9'h040 + i)), 1'b1);
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_rx   = 0;
        exp_drop = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 32'(bus.o_valid), 32'd0);
        check("mrst_ready", 32'(bus.o_ready), 32'd1);
        check("mrst_rx", rx_cnt, 32'd0);
        check("mrst_drop", 32'(drop_cnt), 32'd0);
        check("mrst_seq_err", 32'(seq_err), 32'd0);
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(mk(2'd1, 2'd2, 3'd0, 9'h1ff), 1'b1);
        wait_drain();
        check("post_rst_seq_err", 32'(seq_err), 32'd0);
        check("post_rst_rx", rx_cnt, STATS ? 32'd1 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
